// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter sequencer/arbiter.
//   state_t     : FSM encoding (IDLE, LOAD, RUN)
//   CW_DEFAULT  : default width of the shared loadable counter
//   CNT_MAX     : all-ones terminal value of a default-width counter
//   idx_width() : bits needed to index n requesters (never less than 1)
package counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int CW_DEFAULT = 4;
    localparam logic [CW_DEFAULT-1:0] CNT_MAX = '1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// The search starts at (last_owner + 1) mod NREQ and wraps, so the most
// recent owner gets the lowest priority.
//   req        : per-requester request vector
//   last_owner : index of the most recent owner
//   win_onehot : one-hot winner, all zero when req is zero
//   win_idx    : index of the winner, zero when req is zero
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_owner,
    output logic [NREQ-1:0] win_onehot,
    output logic [IW-1:0]   win_idx
);

    always_comb begin
        int          cand;
        logic [IW-1:0] cidx;
        logic        found;
        // NOTE: every variable written in this block gets a default before
        // any conditional assignment, so no path can leave one unassigned
        // and infer a latch.
        win_onehot = '0;
        win_idx    = '0;
        cand       = 0;
        cidx       = '0;
        found      = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(last_owner) + i) % NREQ;
            cidx = IW'(cand);
            if (!found && req[cidx]) begin
                found            = 1'b1;
                win_onehot[cidx] = 1'b1;
                win_idx          = cidx;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Sequencer/arbiter sharing one free-running loadable counter among NREQ
// requesters. A winner is chosen round-robin in IDLE, the counter is preloaded
// with ~dur so that it reaches all-ones after dur+1 RUN cycles, and a done
// pulse is given in that terminal cycle. Outside a timed window the counter
// is held (parked) at zero.
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   req           : per-requester level request, held until done/abandon
//   dur           : per-requester duration, slice i = dur[i*CW +: CW]
//   gnt           : one-hot grant to the current owner
//   done          : one-cycle completion pulse to the owner
//   busy          : high whenever the FSM is not IDLE
//   cnt_load      : load strobe to the shared counter
//   cnt_load_data : load value to the shared counter
//   cnt_value     : current count from the shared counter
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int CW   = CW_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] dur,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               busy,
    output logic               cnt_load,
    output logic [CW-1:0]      cnt_load_data,
    input  logic [CW-1:0]      cnt_value
);

    localparam int            IW      = idx_width(NREQ);
    localparam logic [CW-1:0] CNT_ALL = '1;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q,  last_d;
    logic [CW-1:0]   dur_q,   dur_d;
    logic [NREQ-1:0] win_onehot;
    logic [IW-1:0]   win_idx;
    logic [CW-1:0]   dur_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_dur
        assign dur_arr[i] = dur[i*CW +: CW];
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req),
        .last_owner (last_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx)
    );

    // Reset leaves last_q at NREQ-1 so requester 0 is searched first.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            dur_q   <= '0;
            last_q  <= IW'(NREQ - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            dur_q   <= dur_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        dur_d         = dur_q;
        last_d        = last_q;
        gnt           = '0;
        done          = '0;
        busy          = 1'b0;
        cnt_load      = 1'b1;   // parked at zero unless timing
        cnt_load_data = '0;

        unique case (state_q)
            IDLE: begin
                if (|win_onehot) begin
                    owner_d = win_idx;
                    dur_d   = dur_arr[win_idx];
                    state_d = LOAD;
                end
            end

            LOAD: begin
                gnt[owner_q] = 1'b1;
                busy         = 1'b1;
                if (!req[owner_q]) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end else begin
                    cnt_load_data = ~dur_q;
                    state_d       = RUN;
                end
            end

            RUN: begin
                gnt[owner_q] = 1'b1;
                busy         = 1'b1;
                cnt_load     = 1'b0;
                // Completion wins over a same-cycle drop of req so that done
                // never depends combinationally on req.
                if (cnt_value == CNT_ALL) begin
                    done[owner_q] = 1'b1;
                    cnt_load      = 1'b1;
                    last_d        = owner_q;
                    state_d       = IDLE;
                end else if (!req[owner_q]) begin
                    cnt_load = 1'b1;
                    last_d   = owner_q;
                    state_d  = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        // While reset is asserted the outputs already show the IDLE values,
        // before the first edge has cleared the state register.
        if (reset) begin
            gnt           = '0;
            done          = '0;
            busy          = 1'b0;
            cnt_load      = 1'b1;
            cnt_load_data = '0;
        end
    end

endmodule
